// File: rtl/router_pkg.sv
// Shared types for the router command/return paths: read tag layout, command FSM states, sizing constants.
package router_pkg;

    localparam int N_MASTERS       = 4;
    localparam int MAX_OUTSTANDING = 8;

    typedef struct packed {
        logic [1:0] master;
        logic [1:0] slave;
        logic [2:0] txn;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } cmd_state_e;

    function automatic tag_t make_tag(input logic [1:0] master,
                                      input logic [1:0] slave,
                                      input logic [2:0] txn);
        tag_t t;
        t.master = master;
        t.slave  = slave;
        t.txn    = txn;
        return t;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first set bit of req_mask searching upward from last+1, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick4
    import router_pkg::*;
(
    input  logic [N_MASTERS-1:0] req_mask,
    input  logic [1:0]           last,
    output logic                 any,
    output logic [1:0]           grant
);

    // Walk the search order backwards so the nearest requester after last wins.
    always_comb begin
        any   = |req_mask;
        grant = last;
        for (int i = 4; i >= 1; i--) begin
            if (req_mask[last + 2'(i)]) begin
                grant = last + 2'(i);
            end
        end
    end

endmodule

// File: rtl/round_robin_cmd.sv
// Round-robin command arbiter for one slave; issues read/write commands and per-read tags.
// Latency: one cycle from eligible m_req to s_req; m_ack the cycle after s_ack (or after the watchdog fires).
// Backpressure: s_req and all s_* fields hold until s_ack; reads stall while a master has 8 outstanding.
module round_robin_cmd
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SLAVE_N    = 0,
    parameter int TIMEOUT    = 255
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            m_req,
    input  logic [3:0]            m_cmd,
    input  logic [ADDR_WIDTH-1:0] m_addr_0,
    input  logic [ADDR_WIDTH-1:0] m_addr_1,
    input  logic [ADDR_WIDTH-1:0] m_addr_2,
    input  logic [ADDR_WIDTH-1:0] m_addr_3,
    input  logic [DATA_WIDTH-1:0] m_wdata_0,
    input  logic [DATA_WIDTH-1:0] m_wdata_1,
    input  logic [DATA_WIDTH-1:0] m_wdata_2,
    input  logic [DATA_WIDTH-1:0] m_wdata_3,
    output logic [3:0]            m_ack,
    output logic [3:0]            m_err,
    output logic                  s_req,
    output logic                  s_cmd,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [6:0]            s_tag,
    input  logic                  s_ack,
    output logic                  rd_issue_valid,
    output logic [6:0]            rd_issue_tag,
    input  logic [3:0]            rd_retire,
    output logic                  busy
);

    localparam logic [1:0] SLV     = 2'(SLAVE_N);
    localparam int         WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [ADDR_WIDTH-1:0] addr_a  [N_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_a [N_MASTERS];
    logic [2:0]            txn_id      [N_MASTERS];
    logic [3:0]            outstanding [N_MASTERS];

    cmd_state_e     state;
    logic [1:0]     g;
    logic [1:0]     last_grant;
    logic [WD_W-1:0] wdog;

    logic [N_MASTERS-1:0] elig;
    logic [N_MASTERS-1:0] cnt_inc;
    logic [N_MASTERS-1:0] cnt_dec;
    logic                 pick_any;
    logic [1:0]           pick_g;
    logic                 rd_accept;

    assign addr_a[0]  = m_addr_0;
    assign addr_a[1]  = m_addr_1;
    assign addr_a[2]  = m_addr_2;
    assign addr_a[3]  = m_addr_3;
    assign wdata_a[0] = m_wdata_0;
    assign wdata_a[1] = m_wdata_1;
    assign wdata_a[2] = m_wdata_2;
    assign wdata_a[3] = m_wdata_3;

    assign busy      = (state != IDLE);
    assign rd_accept = (state == ISSUE) && s_ack && !s_cmd;

    // Writes bypass the outstanding limit; only reads consume return-path slots.
    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            elig[k] = m_req[k]
                   && (addr_a[k][ADDR_WIDTH-1 -: 2] == SLV)
                   && (m_cmd[k] || (outstanding[k] < 4'(MAX_OUTSTANDING)));
        end
    end

    rr_pick4 u_pick (
        .req_mask (elig),
        .last     (last_grant),
        .any      (pick_any),
        .grant    (pick_g)
    );

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            cnt_inc[k] = rd_accept && (g == 2'(k));
            cnt_dec[k] = rd_retire[k] && (outstanding[k] != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_MASTERS; k++) begin
                outstanding[k] <= 4'd0;
                txn_id[k]      <= 3'd0;
            end
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (cnt_inc[k] && !cnt_dec[k]) begin
                    outstanding[k] <= outstanding[k] + 4'd1;
                end else if (cnt_dec[k] && !cnt_inc[k]) begin
                    outstanding[k] <= outstanding[k] - 4'd1;
                end
                if (cnt_inc[k]) begin
                    txn_id[k] <= txn_id[k] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            g              <= 2'd0;
            last_grant     <= 2'd3;
            wdog           <= '0;
            s_req          <= 1'b0;
            s_cmd          <= 1'b0;
            s_addr         <= '0;
            s_wdata        <= '0;
            s_tag          <= '0;
            m_ack          <= 4'd0;
            m_err          <= 4'd0;
            rd_issue_valid <= 1'b0;
            rd_issue_tag   <= '0;
        end else begin
            m_ack          <= 4'd0;
            m_err          <= 4'd0;
            rd_issue_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        g       <= pick_g;
                        s_req   <= 1'b1;
                        s_cmd   <= m_cmd[pick_g];
                        s_addr  <= addr_a[pick_g];
                        s_wdata <= m_cmd[pick_g] ? wdata_a[pick_g] : '0;
                        s_tag   <= make_tag(pick_g, SLV, txn_id[pick_g]);
                        wdog    <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (s_ack) begin
                        s_req      <= 1'b0;
                        m_ack      <= 4'b0001 << g;
                        last_grant <= g;
                        if (!s_cmd) begin
                            rd_issue_valid <= 1'b1;
                            rd_issue_tag   <= s_tag;
                        end
                        state <= ACK;
                    end else if (wdog == WD_LAST) begin
                        // Give up on the slave but still rotate priority.
                        s_req      <= 1'b0;
                        m_ack      <= 4'b0001 << g;
                        m_err      <= 4'b0001 << g;
                        last_grant <= g;
                        state      <= ACK;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
